vector_xnor_accumulator: RTL

- Downstream consumer of the vectorized bit buffer.
- Pulls 8-bit vectors through the buffer's req/vector/valid interface.
- For each vector, scores it against a loaded 8-bit weight as popcount(vector XNOR weight), i.e. the number of matching bits, 0..8.
- Accumulates NB_VECS scores into one result, then presents the result to the next stage with a valid/ready handshake.

---
 rtl/vector_xnor_accumulator_if.sv | 32 +++
 rtl/vector_xnor_accumulator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/vector_xnor_accumulator_if.sv
// Bus between the XNOR accumulator, the upstream vector buffer and the
// downstream result consumer.
//   master : accumulator side (issues req, presents result)
//   slave  : environment side (answers req, accepts result)
interface vector_xnor_accumulator_if #(
    parameter int unsigned ACC_W = 6
);
    logic             req;
    logic [7:0]       vector;
    logic             valid;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output req,
        input  vector,
        input  valid,
        output result,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  req,
        output vector,
        output valid,
        input  result,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/vector_xnor_accumulator.sv
// Pulls 8-bit vectors from the bit buffer one at a time, scores each as
// popcount(vector XNOR weight), sums NB_VECS scores and offers the sum
// downstream with a valid/ready handshake.
// Optional feature macro: VECTOR_XNOR_ACC_THRESHOLD_EN adds a threshold
// input and a registered binarized output result_bit = (result >= threshold).
module vector_xnor_accumulator #(
    parameter int unsigned NB_VECS = 4,
    parameter int unsigned ACC_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [7:0]                 weight_in,
    input  logic                       weight_load,
    vector_xnor_accumulator_if.master  bus
`ifdef VECTOR_XNOR_ACC_THRESHOLD_EN
    ,
    input  logic [ACC_W-1:0]           threshold,
    output logic                       result_bit
`endif
);

    localparam int unsigned CNT_W = (NB_VECS > 1) ? $clog2(NB_VECS) : 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_req;
    logic [7:0]       r_weight;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_result;
    logic             r_result_valid;

    logic [7:0]       w_match;
    logic [3:0]       w_score;
    logic [ACC_W-1:0] w_sum;
    logic             w_last;

    assign bus.req          = r_req;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;

    // Weight register; a vector scored on the load edge still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight <= 8'h00;
        end else if (weight_load) begin
            r_weight <= weight_in;
        end
    end

    // Score = number of bit positions where vector equals weight.
    always_comb begin
        w_match = ~(bus.vector ^ r_weight);
        w_score = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_score = w_score + 4'(w_match[i]);
        end
    end

    assign w_sum  = r_acc + ACC_W'(w_score);
    assign w_last = (r_cnt == CNT_W'(NB_VECS - 1));

    // Request / accumulate / present FSM with registered req and result.
    // req is raised on the edge that enters S_REQ (or while idling there with
    // enable high), so the cycle in S_REQ with req=1 is the request cycle and
    // S_WAIT is the response cycle; this gives one vector per two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_REQ;
            r_req          <= 1'b0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
`ifdef VECTOR_XNOR_ACC_THRESHOLD_EN
            result_bit     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (r_req) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end else if (enable) begin
                        r_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.valid && w_last) begin
                        r_result       <= w_sum;
                        r_result_valid <= 1'b1;
                        r_acc          <= '0;
                        r_cnt          <= '0;
                        r_state        <= S_OUT;
`ifdef VECTOR_XNOR_ACC_THRESHOLD_EN
                        result_bit     <= (w_sum >= threshold);
`endif
                    end else begin
                        if (bus.valid) begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        r_req   <= enable;
                        r_state <= S_REQ;
                    end
                end
                S_OUT: begin
                    if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        r_req          <= enable;
                        r_state        <= S_REQ;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
